// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC sampling, imem handshake, instruction register
module instr_fetch #(
    parameter logic [31:0] IR_RESET = 32'h00000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC_IN,
    output logic        PC_ENA,
    input  logic        FLUSH,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_DATA,
    input  logic        ID_STALL,
    output logic [31:0] IR_OUT,
    output logic [31:0] IR_PC,
    output logic        IR_VALID,
    output logic        FETCH_FAULT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic        valid_q, valid_d;
    logic        pc_misaligned;

    assign pc_misaligned = (PC_IN[1:0] != 2'b00);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            ir_q    <= IR_RESET;
            ir_pc_q <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            valid_q <= valid_d;
        end
    end

    // A redirect overrides everything, including an ACK arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        valid_d = valid_q;
        if (FLUSH) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    addr_d  = PC_IN;
                    state_d = pc_misaligned ? S_FAULT : S_FETCH;
                end
                S_FETCH: begin
                    if (IMEM_ACK) begin
                        ir_d    = IMEM_DATA;
                        ir_pc_d = addr_q;
                        valid_d = 1'b1;
                        state_d = S_FULL;
                    end
                end
                S_FULL: begin
                    if (!ID_STALL) begin
                        valid_d = 1'b0;
                        addr_d  = PC_IN;
                        state_d = pc_misaligned ? S_FAULT : S_FETCH;
                    end
                end
                default: state_d = S_FAULT;
            endcase
        end
    end

    always_comb begin
        IMEM_REQ    = (state_q == S_FETCH);
        IMEM_ADDR   = addr_q;
        PC_ENA      = ((state_q == S_FETCH) && IMEM_ACK) || FLUSH;
        FETCH_FAULT = (state_q == S_FAULT);
        IR_OUT      = ir_q;
        IR_PC       = ir_pc_q;
        IR_VALID    = valid_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch with a behavioural fetch model
module tb_instr_fetch;

    localparam logic [31:0] IR_RST   = 32'h00000013;
    localparam logic [31:0] MEM_KEY  = 32'h20480001;

    logic        CLK = 1'b0;
    logic        RST, FLUSH, ID_STALL, IMEM_ACK;
    logic [31:0] IMEM_DATA;
    logic        PC_ENA, IMEM_REQ, IR_VALID, FETCH_FAULT;
    logic [31:0] IMEM_ADDR, IR_OUT, IR_PC;
    logic [31:0] pc = 32'h00400000;

    logic [31:0] pc_target, pc_set_val;
    logic        pc_set_req, force_ack;
    int          waits, wcnt;
    int          checks = 0, errors = 0;

    instr_fetch #(.IR_RESET(IR_RST)) dut (
        .CLK(CLK), .RST(RST), .PC_IN(pc), .PC_ENA(PC_ENA), .FLUSH(FLUSH),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK),
        .IMEM_DATA(IMEM_DATA), .ID_STALL(ID_STALL), .IR_OUT(IR_OUT),
        .IR_PC(IR_PC), .IR_VALID(IR_VALID), .FETCH_FAULT(FETCH_FAULT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Program counter: advances or loads the redirect target on the falling edge.
    always @(negedge CLK) begin
        if (pc_set_req)  pc = pc_set_val;
        else if (PC_ENA) pc = FLUSH ? pc_target : pc + 32'd4;
    end

    // Memory: acknowledges after 'waits' wait cycles; data is a fixed function of address.
    always @(posedge CLK) begin
        if (IMEM_REQ && !IMEM_ACK) wcnt = wcnt + 1;
        else                       wcnt = 0;
        #2;
        IMEM_ACK  = (IMEM_REQ && wcnt == waits) || force_ack;
        IMEM_DATA = IMEM_ADDR ^ MEM_KEY;
    end

    // Behavioural model: a fetch is either pending, holding a word, faulted, or waiting to sample PC.
    logic        m_known = 1'b0;
    logic        m_sample, m_pending, m_holding, m_fault;
    logic [31:0] m_addr, m_ir, m_irpc;

    always @(posedge CLK) begin
        if (RST) begin
            m_known = 1'b1; m_sample = 1'b1; m_pending = 1'b0; m_holding = 1'b0; m_fault = 1'b0;
            m_addr = 32'h0; m_ir = IR_RST; m_irpc = 32'h0;
        end else if (m_known) begin
            if (FLUSH) begin
                m_sample = 1'b1; m_pending = 1'b0; m_holding = 1'b0; m_fault = 1'b0;
            end else if (m_sample || (m_holding && !ID_STALL)) begin
                m_sample = 1'b0; m_holding = 1'b0;
                m_addr = pc;
                if (pc % 4 != 0) m_fault = 1'b1;
                else             m_pending = 1'b1;
            end else if (m_pending && IMEM_ACK) begin
                m_pending = 1'b0; m_holding = 1'b1;
                m_ir = IMEM_DATA; m_irpc = m_addr;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_known) begin
            chk("m_req",   {31'b0, IMEM_REQ},    {31'b0, m_pending});
            chk("m_addr",  IMEM_ADDR,            m_addr);
            chk("m_ena",   {31'b0, PC_ENA},      {31'b0, FLUSH || (m_pending && IMEM_ACK)});
            chk("m_valid", {31'b0, IR_VALID},    {31'b0, m_holding});
            chk("m_fault", {31'b0, FETCH_FAULT}, {31'b0, m_fault});
            chk("m_ir",    IR_OUT,               m_ir);
            chk("m_irpc",  IR_PC,                m_irpc);
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    int ena_cnt;
    logic req_seen;

    initial begin
        RST = 1'b1; FLUSH = 1'b0; ID_STALL = 1'b0; force_ack = 1'b0;
        pc_set_req = 1'b0; pc_set_val = 32'h0; pc_target = 32'h0;
        waits = 0; wcnt = 0; IMEM_ACK = 1'b0; IMEM_DATA = 32'h0;

        repeat (3) cyc();
        sample();
        chk("rst_req",   {31'b0, IMEM_REQ}, 32'd0);
        chk("rst_addr",  IMEM_ADDR, 32'h0);
        chk("rst_ena",   {31'b0, PC_ENA}, 32'd0);
        chk("rst_ir",    IR_OUT, IR_RST);
        chk("rst_valid", {31'b0, IR_VALID}, 32'd0);
        chk("rst_fault", {31'b0, FETCH_FAULT}, 32'd0);

        // First fetch after reset, decode stalled so the word stays visible.
        cyc(); RST = 1'b0; ID_STALL = 1'b1;
        sample(); ena_cnt = int'(PC_ENA);
        chk("idle_req", {31'b0, IMEM_REQ}, 32'd0);
        cyc(); sample(); ena_cnt += int'(PC_ENA);
        chk("first_addr", IMEM_ADDR, 32'h00400000);
        chk("first_req",  {31'b0, IMEM_REQ}, 32'd1);
        cyc(); sample(); ena_cnt += int'(PC_ENA);
        chk("first_ena_pulses", ena_cnt, 32'd1);
        chk("first_ir",    IR_OUT, 32'h20080001);
        chk("first_irpc",  IR_PC, 32'h00400000);
        chk("first_valid", {31'b0, IR_VALID}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            cyc(); sample();
            chk("stall_ir",    IR_OUT, 32'h20080001);
            chk("stall_valid", {31'b0, IR_VALID}, 32'd1);
            chk("stall_req",   {31'b0, IMEM_REQ}, 32'd0);
            chk("stall_ena",   {31'b0, PC_ENA}, 32'd0);
        end

        // Release stall; next fetch uses three wait cycles.
        waits = 3;
        cyc(); ID_STALL = 1'b0;
        sample();
        chk("consume_ena", {31'b0, PC_ENA}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(); sample();
            chk("wait_req",  {31'b0, IMEM_REQ}, 32'd1);
            chk("wait_addr", IMEM_ADDR, 32'h00400004);
            chk("wait_ena",  {31'b0, PC_ENA}, (i == 3) ? 32'd1 : 32'd0);
        end
        cyc(); waits = 0;
        sample();
        chk("wait_ir",    IR_OUT, 32'h20080005);
        chk("wait_irpc",  IR_PC, 32'h00400004);
        chk("wait_valid", {31'b0, IR_VALID}, 32'd1);

        // Redirect coincident with ACK: data must be dropped.
        cyc(); FLUSH = 1'b1; pc_target = 32'h00400100;
        sample();
        chk("flush_addr", IMEM_ADDR, 32'h00400008);
        chk("flush_ack",  {31'b0, IMEM_ACK}, 32'd1);
        chk("flush_ena",  {31'b0, PC_ENA}, 32'd1);
        cyc(); FLUSH = 1'b0; ID_STALL = 1'b1;
        sample();
        chk("flush_valid", {31'b0, IR_VALID}, 32'd0);
        chk("flush_ir",    IR_OUT, 32'h20080005);
        chk("flush_req",   {31'b0, IMEM_REQ}, 32'd0);
        cyc(); sample();
        chk("redir_addr", IMEM_ADDR, 32'h00400100);
        chk("redir_req",  {31'b0, IMEM_REQ}, 32'd1);

        // Misaligned PC presented at consume time.
        cyc(); pc_set_req = 1'b1; pc_set_val = 32'h00400002;
        sample();
        chk("redir_ir", IR_OUT, 32'h20080101);
        cyc(); pc_set_req = 1'b0; ID_STALL = 1'b0;
        sample();
        cyc(); force_ack = 1'b1;
        sample();
        chk("fault_flag",  {31'b0, FETCH_FAULT}, 32'd1);
        chk("fault_valid", {31'b0, IR_VALID}, 32'd0);
        chk("fault_ena",   {31'b0, PC_ENA}, 32'd0);
        req_seen = IMEM_REQ;
        for (int i = 0; i < 3; i++) begin
            cyc(); sample();
            req_seen = req_seen | IMEM_REQ;
        end
        chk("fault_no_req", {31'b0, req_seen}, 32'd0);
        chk("fault_sticky", {31'b0, FETCH_FAULT}, 32'd1);

        waits = 3;
        cyc(); force_ack = 1'b0; FLUSH = 1'b1; pc_target = 32'h00400010;
        sample();
        chk("unfault_ena", {31'b0, PC_ENA}, 32'd1);
        cyc(); FLUSH = 1'b0;
        sample();
        chk("unfault_flag", {31'b0, FETCH_FAULT}, 32'd0);
        cyc(); sample();
        chk("resume_addr", IMEM_ADDR, 32'h00400010);
        chk("resume_req",  {31'b0, IMEM_REQ}, 32'd1);

        // Reset in the middle of a wait cycle.
        cyc(); RST = 1'b1;
        sample();
        chk("rstw_ena", {31'b0, PC_ENA}, 32'd0);
        chk("rstw_req", {31'b0, IMEM_REQ}, 32'd1);
        cyc(); sample();
        chk("rstw_req2",  {31'b0, IMEM_REQ}, 32'd0);
        chk("rstw_addr",  IMEM_ADDR, 32'h0);
        chk("rstw_ir",    IR_OUT, IR_RST);
        chk("rstw_irpc",  IR_PC, 32'h0);
        chk("rstw_valid", {31'b0, IR_VALID}, 32'd0);
        chk("rstw_fault", {31'b0, FETCH_FAULT}, 32'd0);
        chk("rstw_ena2",  {31'b0, PC_ENA}, 32'd0);
        cyc(); RST = 1'b0;
        repeat (8) begin cyc(); sample(); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
